// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one pipelined multiplier between NUM_REQ requesters.
// Optional build macro: MULT_SHARE_SIGNED_EN selects a two's-complement multiply.
`timescale 1ns/1ps

module mult_share_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]     req_a,
  input  logic [NUM_REQ*DATA_W-1:0]     req_b,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [NUM_REQ*2*DATA_W-1:0]   rsp_data,
  output logic                          busy,
  output logic [31:0]                   issue_cnt
);

  localparam int unsigned PROD_W  = 2 * DATA_W;
  localparam int unsigned TAG_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned NUM_STG = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

  typedef enum logic [1:0] {
    SLOT_IDLE     = 2'd0,
    SLOT_INFLIGHT = 2'd1,
    SLOT_DONE     = 2'd2
  } slot_e;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [PROD_W-1:0] prod;
  } op_t;

  slot_e                     r_slot     [NUM_REQ];
  slot_e                     w_slot_nxt [NUM_REQ];
  logic [TAG_W-1:0]          r_ptr;
  logic [TAG_W-1:0]          w_ptr_nxt;
  logic [NUM_REQ-1:0]        w_elig;
  logic [NUM_REQ-1:0]        w_grant;
  logic                      w_accept;
  logic [TAG_W-1:0]          w_gidx;
  logic [DATA_W-1:0]         w_a;
  logic [DATA_W-1:0]         w_b;
  logic [PROD_W-1:0]         w_prod;
  op_t                       w_issue_op;
  logic                      w_exit_vld;
  op_t                       w_exit_op;
  logic [NUM_REQ-1:0]        w_exit_hit;
  logic                      w_pipe_any_nxt;
  logic [NUM_REQ-1:0]        w_rsp_valid_nxt;
  logic [NUM_REQ-1:0]        r_rsp_valid;
  logic [NUM_REQ*PROD_W-1:0] r_rsp_data;
  logic                      r_busy;
  logic [CNT_W-1:0]          r_issue_cnt;

  // Round-robin search from the registered pointer; nothing is granted while reset is held.
  always_comb begin
    int unsigned v_idx;
    v_idx    = 0;
    w_elig   = '0;
    w_grant  = '0;
    w_accept = 1'b0;
    w_gidx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_elig[i] = ARESETN && req_valid[i] && (r_slot[i] == SLOT_IDLE);
    end
    for (int off = 0; off < NUM_REQ; off++) begin
      v_idx = (32'(r_ptr) + 32'(off)) % NUM_REQ;
      if (!w_accept && w_elig[v_idx]) begin
        w_accept       = 1'b1;
        w_gidx         = TAG_W'(v_idx);
        w_grant[v_idx] = 1'b1;
      end
    end
  end

  assign w_a = req_a[w_gidx*DATA_W +: DATA_W];
  assign w_b = req_b[w_gidx*DATA_W +: DATA_W];

`ifdef MULT_SHARE_SIGNED_EN
  logic signed [PROD_W-1:0] w_sa;
  logic signed [PROD_W-1:0] w_sb;
  assign w_sa   = PROD_W'($signed(w_a));
  assign w_sb   = PROD_W'($signed(w_b));
  assign w_prod = $unsigned(w_sa * w_sb);
`else
  assign w_prod = PROD_W'(w_a) * PROD_W'(w_b);
`endif

  assign w_issue_op.tag  = w_gidx;
  assign w_issue_op.prod = w_prod;

  // The response register is the last latency stage, so only MUL_LAT-1 pipe stages exist.
  if (MUL_LAT == 1) begin : g_direct
    assign w_exit_vld     = w_accept;
    assign w_exit_op      = w_issue_op;
    assign w_pipe_any_nxt = 1'b0;
  end else begin : g_pipe
    localparam logic [NUM_STG-1:0] KEEP_MASK = {NUM_STG{1'b1}} >> 1;
    logic [NUM_STG-1:0] r_vld;
    op_t                r_op [NUM_STG];

    always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
        r_vld <= '0;
        for (int j = 0; j < NUM_STG; j++) begin
          r_op[j] <= '0;
        end
      end else begin
        r_vld[0] <= w_accept;
        r_op[0]  <= w_issue_op;
        for (int j = 1; j < NUM_STG; j++) begin
          r_vld[j] <= r_vld[j-1];
          r_op[j]  <= r_op[j-1];
        end
      end
    end

    assign w_exit_vld     = r_vld[NUM_STG-1];
    assign w_exit_op      = r_op[NUM_STG-1];
    assign w_pipe_any_nxt = w_accept | (|(r_vld & KEEP_MASK));
  end

  always_comb begin
    w_exit_hit = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_exit_hit[i] = w_exit_vld && (w_exit_op.tag == TAG_W'(i));
    end
  end

  // Slot next-state and pointer update.
  always_comb begin
    w_ptr_nxt       = r_ptr;
    w_rsp_valid_nxt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_slot_nxt[i] = r_slot[i];
      case (r_slot[i])
        SLOT_IDLE:     if (w_grant[i]) w_slot_nxt[i] = SLOT_INFLIGHT;
        SLOT_INFLIGHT: w_slot_nxt[i] = SLOT_INFLIGHT;
        SLOT_DONE:     if (rsp_ready[i]) w_slot_nxt[i] = SLOT_IDLE;
        default:       w_slot_nxt[i] = SLOT_IDLE;
      endcase
      if (w_exit_hit[i]) w_slot_nxt[i] = SLOT_DONE;
      w_rsp_valid_nxt[i] = (w_slot_nxt[i] == SLOT_DONE);
    end
    if (w_accept) begin
      w_ptr_nxt = (w_gidx == TAG_W'(NUM_REQ - 1)) ? '0 : w_gidx + TAG_W'(1);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_slot[i] <= SLOT_IDLE;
      end
      r_ptr       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
      r_issue_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        r_slot[i] <= w_slot_nxt[i];
        if (w_exit_hit[i]) r_rsp_data[i*PROD_W +: PROD_W] <= w_exit_op.prod;
      end
      r_ptr       <= w_ptr_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_busy      <= w_pipe_any_nxt | (|w_rsp_valid_nxt);
      r_issue_cnt <= r_issue_cnt + CNT_W'(w_accept);
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_busy;
  assign issue_cnt = r_issue_cnt;

endmodule

// File: tb/tb_mult_share_sched.sv
// Bench for mult_share_sched: directed and random steps checked against a slot-level reference model.
`timescale 1ns/1ps

module tb_mult_share_sched;

  localparam int unsigned NR  = 4;
  localparam int unsigned DW  = 16;
  localparam int unsigned LAT = 3;
  localparam int unsigned PW  = 2 * DW;

  logic              ACLK = 1'b0;
  logic              ARESETN;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DW-1:0]  req_a;
  logic [NR*DW-1:0]  req_b;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready;
  logic [NR*PW-1:0]  rsp_data;
  logic              busy;
  logic [31:0]       issue_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: 0 idle, 1 in flight, 2 result waiting
  int          m_st   [NR];
  int          m_rem  [NR];
  logic [PW-1:0] m_res [NR];
  logic [PW-1:0] m_pend[NR];
  int          m_ptr;
  logic [31:0] m_cnt;

  mult_share_sched #(.NUM_REQ(NR), .DATA_W(DW), .MUL_LAT(LAT)) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .issue_cnt (issue_cnt)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [PW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint pa;
    longint pb;
    pa = longint'(a);
    pb = longint'(b);
`ifdef MULT_SHARE_SIGNED_EN
    if (a[DW-1]) pa = pa - (longint'(1) << DW);
    if (b[DW-1]) pb = pb - (longint'(1) << DW);
`endif
    return PW'(pa * pb);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_st[i]   = 0;
      m_rem[i]  = 0;
      m_res[i]  = '0;
      m_pend[i] = '0;
    end
    m_ptr = 0;
    m_cnt = '0;
  endtask

  function automatic int exp_grant();
    int i;
    for (int off = 0; off < NR; off++) begin
      i = (m_ptr + off) % NR;
      if (req_valid[i] && m_st[i] == 0) return i;
    end
    return -1;
  endfunction

  task automatic check_outs();
    logic [NR-1:0]    ev;
    logic [NR*PW-1:0] ed;
    logic             eb;
    ev = '0;
    ed = '0;
    eb = 1'b0;
    for (int i = 0; i < NR; i++) begin
      ev[i] = (m_st[i] == 2);
      ed[i*PW +: PW] = m_res[i];
      if (m_st[i] != 0) eb = 1'b1;
    end
    check("rsp_valid", 128'(rsp_valid), 128'(ev));
    check("rsp_data",  128'(rsp_data),  128'(ed));
    check("busy",      128'(busy),      128'(eb));
    check("issue_cnt", 128'(issue_cnt), 128'(m_cnt));
  endtask

  // One clock: check the grant before the edge, advance the model, check registered outputs after it.
  task automatic cycle();
    int g;
    logic [NR-1:0] er;
    #1;
    g  = exp_grant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    check("req_ready", 128'(req_ready), 128'(er));
    @(posedge ACLK);
    for (int i = 0; i < NR; i++) begin
      if (m_st[i] == 2 && rsp_ready[i]) m_st[i] = 0;
    end
    for (int i = 0; i < NR; i++) begin
      if (m_st[i] == 1) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_st[i]  = 2;
          m_res[i] = m_pend[i];
        end
      end
    end
    if (g >= 0) begin
      m_pend[g] = ref_mul(req_a[g*DW +: DW], req_b[g*DW +: DW]);
      m_st[g]   = 1;
      m_rem[g]  = int'(LAT) - 1;
      if (m_rem[g] == 0) begin
        m_st[g]  = 2;
        m_res[g] = m_pend[g];
      end
      m_ptr = (g + 1) % NR;
      m_cnt = m_cnt + 32'd1;
    end
    #1;
    check_outs();
  endtask

  task automatic rand_ops();
    req_a = (NR*DW)'({$urandom, $urandom});
    req_b = (NR*DW)'({$urandom, $urandom});
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = '1;
    repeat (LAT + 2) cycle();
  endtask

  initial begin
    logic [PW-1:0] e_max;
    logic [PW-1:0] e_neg;
    logic [31:0]   wrapv [3];
    wrapv[0] = 32'hFFFF_FFFF;
    wrapv[1] = 32'h0000_0000;
    wrapv[2] = 32'h0000_0001;
`ifdef MULT_SHARE_SIGNED_EN
    e_max = 32'h0000_0001;
    e_neg = 32'hFFFF_FFFE;
`else
    e_max = 32'hFFFE_0001;
    e_neg = 32'h0001_FFFE;
`endif

    // Reset with requests pending: nothing may be granted
    ARESETN   = 1'b0;
    req_valid = '1;
    rsp_ready = '0;
    rand_ops();
    repeat (2) @(posedge ACLK);
    #1;
    model_reset();
    check_outs();
    check("rst_req_ready", 128'(req_ready), 128'(0));
    ARESETN   = 1'b1;

    // Single op 3*7 on requester 0, result held without rsp_ready
    req_valid = 4'b0001;
    req_a     = (NR*DW)'(3);
    req_b     = (NR*DW)'(7);
    cycle();
    req_valid = '0;
    repeat (LAT + 5) cycle();
    check("t1_data",  128'(rsp_data[PW-1:0]), 128'(32'd21));
    check("t1_valid", 128'(rsp_valid[0]), 128'(1));
    check("t1_busy",  128'(busy), 128'(1));
    check("t1_cnt",   128'(issue_cnt), 128'(1));
    rsp_ready = 4'b0001;
    cycle();
    check("t1_idle", 128'(busy), 128'(0));

    // All requesters valid, responses consumed immediately
    req_valid = '1;
    rsp_ready = '1;
    for (int k = 0; k < 12; k++) begin
      rand_ops();
      cycle();
    end

    // Requester 2 blocked while its result waits, freed only after the handshake edge
    drain();
    req_valid = 4'b0100;
    rsp_ready = '0;
    rand_ops();
    repeat (LAT + 4) cycle();
    check("t3_blocked", 128'(req_ready[2]), 128'(0));
    rsp_ready = 4'b0100;
    cycle();
    rsp_ready = '0;
    cycle();
    drain();

    // Boundary operands
    req_a     = {16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000};
    req_b     = {16'h0002, 16'h0000, 16'hFFFF, 16'h0000};
    req_valid = 4'b1010;
    rsp_ready = '0;
    repeat (LAT + 3) cycle();
    check("t4_max", 128'(rsp_data[1*PW +: PW]), 128'(e_max));
    check("t4_neg", 128'(rsp_data[3*PW +: PW]), 128'(e_neg));
    drain();

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      req_valid = NR'($urandom);
      rsp_ready = NR'($urandom);
      rand_ops();
      cycle();
    end

    // Reset mid-pipeline
    drain();
    req_valid = '1;
    rsp_ready = '0;
    rand_ops();
    repeat (3) cycle();
    ARESETN = 1'b0;
    #1;
    model_reset();
    check_outs();
    check("mid_rst_ready", 128'(req_ready), 128'(0));
    @(posedge ACLK);
    #1;
    check_outs();
    ARESETN = 1'b1;
    #1;
    check("post_rst_grant", 128'(req_ready), 128'(4'b0001));
    repeat (LAT + 4) cycle();

    // Issue counter wrap
    drain();
    force dut.r_issue_cnt = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    cycle();
    release dut.r_issue_cnt;
    req_valid = '1;
    rsp_ready = '0;
    for (int k = 0; k < 3; k++) begin
      rand_ops();
      cycle();
      check("wrap_cnt", 128'(issue_cnt), 128'(wrapv[k]));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
